memory_port_arbiter: RTL and testbench

- Shares one single-ported, variable-latency memory bus between the IF stage (instruction fetch) and the MEM stage (load/store).
- Sequences each bus transaction through a small FSM and returns data to the owning stage.
- Drives the global pipeline stall while either stage waits.
- Sits between the pipeline stages and the external memory, replacing separate instruction and data memories.

---
 rtl/memory_port_arbiter.sv | 99 +++++++++
 tb/tb_memory_port_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares one variable-latency memory bus between the IF and MEM pipeline stages
// Ports: clock/reset (sync, active-high); ifRequest/ifAddress -> ifReady/ifInstruction;
//   memRequest/memWrite/memAddress/memWriteData -> memReady/memReadData;
//   busRequest/busWrite/busAddress/busWriteData <- busAck/busReadData; busTimeout; shouldStall.
// Optional: MEMORY_PORT_ARBITER_PERF_COUNTERS_EN adds stallCycleCount and transactionCount.
module memory_port_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int STARVATION_LIMIT = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ifRequest,
  input  logic [ADDRESS_WIDTH-1:0] ifAddress,
  output logic                     ifReady,
  output logic [31:0]              ifInstruction,
  input  logic                     memRequest,
  input  logic                     memWrite,
  input  logic [ADDRESS_WIDTH-1:0] memAddress,
  input  logic [31:0]              memWriteData,
  output logic                     memReady,
  output logic [31:0]              memReadData,
  output logic                     busRequest,
  output logic                     busWrite,
  output logic [ADDRESS_WIDTH-1:0] busAddress,
  output logic [31:0]              busWriteData,
  input  logic                     busAck,
  input  logic [31:0]              busReadData,
  output logic                     busTimeout,
  output logic                     shouldStall
`ifdef MEMORY_PORT_ARBITER_PERF_COUNTERS_EN
  ,
  output logic [31:0]              stallCycleCount,
  output logic [31:0]              transactionCount
`endif
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, DONE} stateType;
  stateType state, nextState;
  logic [7:0] timeoutCount;
  logic [3:0] starveCount;
  logic busy, expired, finish, grantMem, grantIf, granting;
  always_comb begin
    busy = state == BUSY_IF || state == BUSY_MEM;
    expired = busy && !busAck && timeoutCount == 8'(TIMEOUT_CYCLES - 1);
    finish = busy && (busAck || expired);
    // MEM wins ties until IF has waited through STARVATION_LIMIT MEM grants
    grantMem = memRequest && (!ifRequest || starveCount != 4'(STARVATION_LIMIT));
    grantIf = ifRequest && !grantMem;
    granting = state == IDLE && (grantMem || grantIf);
    nextState = state == IDLE ? (grantMem ? BUSY_MEM : grantIf ? BUSY_IF : IDLE) :
                state == DONE ? IDLE :
                finish ? DONE : state;
  end
  assign shouldStall = (ifRequest && !ifReady) || (memRequest && !memReady);
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      timeoutCount <= '0;
      starveCount <= '0;
      ifReady <= 1'b0;
      memReady <= 1'b0;
      busTimeout <= 1'b0;
      busRequest <= 1'b0;
      busWrite <= 1'b0;
      busAddress <= '0;
      busWriteData <= '0;
      ifInstruction <= '0;
      memReadData <= '0;
    end else begin
      state <= nextState;
      busRequest <= nextState == BUSY_IF || nextState == BUSY_MEM;
      ifReady <= state == BUSY_IF && finish;
      memReady <= state == BUSY_MEM && finish;
      busTimeout <= expired;
      if (granting) begin
        busAddress <= grantMem ? memAddress : ifAddress;
        busWrite <= grantMem && memWrite;
        busWriteData <= grantMem ? memWriteData : '0;
        timeoutCount <= '0;
        starveCount <= grantMem ? starveCount + 4'(ifRequest) : '0;
      end else if (busy && !busAck) begin
        timeoutCount <= timeoutCount + 8'd1;
      end
      if (state == BUSY_IF && finish) ifInstruction <= busAck ? busReadData : '0;
      if (state == BUSY_MEM && finish && !busWrite) memReadData <= busAck ? busReadData : '0;
    end
  end
`ifdef MEMORY_PORT_ARBITER_PERF_COUNTERS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stallCycleCount <= '0;
      transactionCount <= '0;
    end else begin
      stallCycleCount <= stallCycleCount + 32'(shouldStall && stallCycleCount != '1);
      transactionCount <= transactionCount + 32'(finish && transactionCount != '1);
    end
  end
`endif
endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb_memory_port_arbiter: directed self-checking bench for memory_port_arbiter
module tb_memory_port_arbiter;
  logic clock = 1'b0, reset = 1'b1;
  logic ifRequest = 1'b0, memRequest = 1'b0, memWrite = 1'b0, busAck = 1'b0;
  logic [31:0] ifAddress = '0, memAddress = '0, memWriteData = '0, busReadData = '0;
  logic ifReady, memReady, busRequest, busWrite, busTimeout, shouldStall;
  logic [31:0] ifInstruction, memReadData, busAddress, busWriteData;
`ifdef MEMORY_PORT_ARBITER_PERF_COUNTERS_EN
  logic [31:0] stallCycleCount, transactionCount;
`endif
  int checks = 0, failures = 0;

  memory_port_arbiter #(.ADDRESS_WIDTH(32), .TIMEOUT_CYCLES(8), .STARVATION_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .ifRequest(ifRequest), .ifAddress(ifAddress), .ifReady(ifReady), .ifInstruction(ifInstruction),
    .memRequest(memRequest), .memWrite(memWrite), .memAddress(memAddress),
    .memWriteData(memWriteData), .memReady(memReady), .memReadData(memReadData),
    .busRequest(busRequest), .busWrite(busWrite), .busAddress(busAddress),
    .busWriteData(busWriteData), .busAck(busAck), .busReadData(busReadData),
    .busTimeout(busTimeout), .shouldStall(shouldStall)
`ifdef MEMORY_PORT_ARBITER_PERF_COUNTERS_EN
    , .stallCycleCount(stallCycleCount), .transactionCount(transactionCount)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic access(input bit isMem, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int w, input logic [31:0] rdata, input logic [31:0] expData);
    if (isMem) begin
      memRequest = 1'b1; memWrite = wr; memAddress = addr; memWriteData = wdata;
    end else begin
      ifRequest = 1'b1; ifAddress = addr;
    end
    #1 check("stallReq", shouldStall, 1);
    tick;
    for (int i = 0; i < w; i++) begin
      check("busReqWait", busRequest, 1);
      check("busWrHeld", busWrite, wr);
      tick;
    end
    busAck = 1'b1; busReadData = rdata;
    check("busReq", busRequest, 1);
    check("busAddr", busAddress, addr);
    check("busWrite", busWrite, wr);
    if (wr) check("busWdata", busWriteData, wdata);
    tick;
    busAck = 1'b0;
    check("ifReady", ifReady, !isMem);
    check("memReady", memReady, isMem);
    check("busTimeout", busTimeout, 0);
    check("busReqDone", busRequest, 0);
    check("stallDone", shouldStall, 0);
    check(isMem ? "memData" : "ifData", isMem ? memReadData : ifInstruction, expData);
    ifRequest = 1'b0; memRequest = 1'b0; memWrite = 1'b0;
    tick;
    check("readyPulse", ifReady | memReady, 0);
    check("busReqIdle", busRequest, 0);
  endtask

  initial begin
    tick; tick;
    check("rstBusReq", busRequest, 0);
    check("rstReady", {ifReady, memReady, busTimeout}, 0);
    check("rstStall", shouldStall, 0);
    check("rstData", {ifInstruction, memReadData}, 0);
    check("rstBus", {busWrite, busAddress, busWriteData}, 0);
    reset = 1'b0;
    tick;
    check("idleNoReq", busRequest, 0);

    access(0, 0, 32'h40, 32'h0, 1, 32'h20080005, 32'h20080005);
    access(1, 1, 32'h100, 32'h1234ABCD, 2, 32'hDEADBEEF, 32'h0);
    access(1, 0, 32'h100, 32'h0, 1, 32'h1234ABCD, 32'h1234ABCD);

    ifRequest = 1'b1; ifAddress = 32'h200;
    memRequest = 1'b1; memWrite = 1'b0; memAddress = 32'h300;
    for (int i = 0; i < 6; i++) begin
      bit expIf;
      expIf = (i == 4);
      tick;
      check("ctGrant", busAddress, expIf ? 32'h200 : 32'h300);
      check("ctBusReq", busRequest, 1);
      busAck = 1'b1; busReadData = 32'hC0DE0000 + 32'(i);
      tick;
      busAck = 1'b0;
      check("ctIfReady", ifReady, expIf);
      check("ctMemReady", memReady, !expIf);
      check("ctData", expIf ? ifInstruction : memReadData, 32'hC0DE0000 + 32'(i));
      tick;
      check("ctNoDup", ifReady | memReady, 0);
    end
    ifRequest = 1'b0; memRequest = 1'b0;
    tick;

    memRequest = 1'b1; memWrite = 1'b0; memAddress = 32'h500;
    tick;
    for (int i = 0; i < 8; i++) begin
      check("toBusReq", busRequest, 1);
      check("toNoReady", memReady, 0);
      tick;
    end
    check("toReady", memReady, 1);
    check("toFlag", busTimeout, 1);
    check("toBusDrop", busRequest, 0);
    check("toData", memReadData, 0);
    memRequest = 1'b0;
    tick;
    check("toPulse", {busTimeout, memReady}, 0);

    ifRequest = 1'b1; ifAddress = 32'h600;
    tick;
    check("rmBusReq", busRequest, 1);
    reset = 1'b1; ifRequest = 1'b0;
    tick;
    check("rmBusDrop", busRequest, 0);
    check("rmOutputs", {ifReady, memReady, busTimeout, busWrite, busAddress}, 0);
    check("rmData", {ifInstruction, memReadData}, 0);
    reset = 1'b0; busAck = 1'b1; busReadData = 32'hBAD;
    tick;
    busAck = 1'b0;
    check("rmStaleAck", {ifReady, memReady, busTimeout, busRequest}, 0);
    check("rmNoLatch", ifInstruction, 0);
    tick;
    check("rmNoReady", ifReady, 0);
    access(0, 0, 32'h600, 32'h0, 0, 32'h55, 32'h55);

`ifdef MEMORY_PORT_ARBITER_PERF_COUNTERS_EN
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("pfRstStall", stallCycleCount, 0);
    check("pfRstTx", transactionCount, 0);
    access(0, 0, 32'h10, 32'h0, 0, 32'h1, 32'h1);
    access(1, 0, 32'h20, 32'h0, 1, 32'h2, 32'h2);
    access(1, 1, 32'h30, 32'h3, 0, 32'h0, 32'h2);
    check("pfStall", stallCycleCount, 7);
    check("pfTx", transactionCount, 3);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("pfClrStall", stallCycleCount, 0);
    check("pfClrTx", transactionCount, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
